// File: rtl/pcs_lane_pkg.sv
// Shared PCS lane constants and the lane-ID to one-hot decode used by the TX sequencer and the RX decode.
// The same decode is used by the LANE_SEQ_CHECK_EN integrity checker.
package pcs_lane_pkg;

    localparam int NB_LANES_DEF     = 20;
    localparam int NB_AM_PERIOD_DEF = 16383;
    localparam int NB_LANE_ID_DEF   = $clog2(NB_LANES_DEF);
    localparam int MAX_LANES        = 64;

    // Callers truncate the result to their own lane count.
    function automatic logic [MAX_LANES-1:0] lane_id_to_onehot(input logic [31:0] id);
        logic [MAX_LANES-1:0] one;
        one = MAX_LANES'(1);
        return one << id;
    endfunction

endpackage

// File: rtl/am_period_counter.sv
// Alignment-marker round tracker: one AM round, then NB_AM_PERIOD data rounds, advanced once per round.
module am_period_counter #(
    parameter int NB_AM_PERIOD  = 16383,
    parameter int NB_PERIOD_CNT = $clog2(NB_AM_PERIOD + 1)
) (
    input  logic clock,
    input  logic rst_n,
    input  logic restart,
    input  logic round_end,
    output logic am_round
);

    localparam logic [NB_PERIOD_CNT-1:0] LAST_DATA_ROUND = NB_PERIOD_CNT'(NB_AM_PERIOD - 1);

    logic [NB_PERIOD_CNT-1:0] period_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            am_round   <= 1'b1;
            period_cnt <= '0;
        end else if (restart) begin
            am_round   <= 1'b1;
            period_cnt <= '0;
        end else if (round_end) begin
            if (am_round) begin
                am_round   <= 1'b0;
                period_cnt <= '0;
            end else if (period_cnt == LAST_DATA_ROUND) begin
                am_round   <= 1'b1;
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + NB_PERIOD_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/tx_lane_id_sequencer.sv
// Round-robin TX PCS lane index (binary + one-hot) with alignment-marker round flag.
// Optional one-hot integrity checker enabled by macro LANE_SEQ_CHECK_EN.
module tx_lane_id_sequencer
    import pcs_lane_pkg::*;
#(
    parameter int NB_LANES      = NB_LANES_DEF,
    parameter int NB_LANE_ID    = $clog2(NB_LANES),
    parameter int NB_AM_PERIOD  = NB_AM_PERIOD_DEF,
    parameter int NB_PERIOD_CNT = $clog2(NB_AM_PERIOD + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_rst_n,
    input  logic                  i_soft_rst,
    input  logic                  i_valid,
    output logic [NB_LANE_ID-1:0] o_lane_id,
    output logic [NB_LANES-1:0]   o_lane_onehot,
    output logic                  o_am_insert,
    output logic                  o_last_lane,
    output logic                  o_seq_err
);

    localparam logic [NB_LANE_ID-1:0] LAST_LANE = NB_LANE_ID'(NB_LANES - 1);

    logic [NB_LANE_ID-1:0] lane_q;
    logic [NB_LANE_ID-1:0] lane_nxt;
    logic [NB_LANES-1:0]   onehot_q;
    logic [NB_LANES-1:0]   onehot_nxt;
    logic [NB_LANES-1:0]   onehot_rot;
    logic                  advance;
    logic                  round_end;
    logic                  am_round;

    // A soft restart swallows a simultaneous valid: that slot is never counted.
    assign advance    = i_valid && !i_soft_rst;
    assign round_end  = advance && (lane_q == LAST_LANE);
    assign lane_nxt   = (lane_q == LAST_LANE) ? '0 : lane_q + NB_LANE_ID'(1);
    assign onehot_rot = {onehot_q[NB_LANES-2:0], onehot_q[NB_LANES-1]};

`ifdef LANE_SEQ_CHECK_EN
    logic [NB_LANES-1:0] onehot_dec;
    logic [NB_LANES-1:0] onehot_resync;
    logic                mismatch;
    logic                seq_err_q;

    assign onehot_dec    = NB_LANES'(lane_id_to_onehot(32'(lane_q)));
    assign onehot_resync = NB_LANES'(lane_id_to_onehot(32'(lane_nxt)));
    assign mismatch      = (onehot_q != onehot_dec);
    // Once corrupted, rebuild the one-hot from the binary lane instead of rotating garbage.
    assign onehot_nxt    = (mismatch || seq_err_q) ? onehot_resync : onehot_rot;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seq_err_q <= 1'b0;
        end else if (i_soft_rst) begin
            seq_err_q <= 1'b0;
        end else if (mismatch) begin
            seq_err_q <= 1'b1;
        end
    end

    assign o_seq_err = seq_err_q;
`else
    assign onehot_nxt = onehot_rot;
    assign o_seq_err  = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lane_q   <= '0;
            onehot_q <= NB_LANES'(1);
        end else if (i_soft_rst) begin
            lane_q   <= '0;
            onehot_q <= NB_LANES'(1);
        end else if (advance) begin
            lane_q   <= lane_nxt;
            onehot_q <= onehot_nxt;
        end
    end

    am_period_counter #(
        .NB_AM_PERIOD (NB_AM_PERIOD),
        .NB_PERIOD_CNT(NB_PERIOD_CNT)
    ) u_am_period_counter (
        .clock    (i_clock),
        .rst_n    (i_rst_n),
        .restart  (i_soft_rst),
        .round_end(round_end),
        .am_round (am_round)
    );

    assign o_lane_id     = lane_q;
    assign o_lane_onehot = onehot_q;
    assign o_am_insert   = am_round;
    assign o_last_lane   = (lane_q == LAST_LANE);

endmodule

// File: tb/tb_tx_lane_id_sequencer.sv
// Bench for tx_lane_id_sequencer (NB_LANES=20, NB_AM_PERIOD=4); model counts consumed slots since restart.
module tb_tx_lane_id_sequencer;

    localparam int NL = 20;
    localparam int AP = 4;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          soft_rst;
    logic          valid;
    logic [LW-1:0] lane_id;
    logic [NL-1:0] lane_onehot;
    logic          am_insert;
    logic          last_lane;
    logic          seq_err;

    int tests = 0;
    int fails = 0;
    int slot_cnt = 0;
    logic [LW-1:0] exp_q[$];

    tx_lane_id_sequencer #(
        .NB_LANES    (NL),
        .NB_AM_PERIOD(AP)
    ) dut (
        .i_clock      (clk),
        .i_rst_n      (rst_n),
        .i_soft_rst   (soft_rst),
        .i_valid      (valid),
        .o_lane_id    (lane_id),
        .o_lane_onehot(lane_onehot),
        .o_am_insert  (am_insert),
        .o_last_lane  (last_lane),
        .o_seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    // Reference: slot n sits on lane n%NL of round n/NL; every (AP+1)-th round is an AM round.
    function automatic logic [LW-1:0] m_lane();
        return LW'(slot_cnt % NL);
    endfunction

    function automatic logic m_am();
        return ((slot_cnt / NL) % (AP + 1)) == 0;
    endfunction

    function automatic logic [NL-1:0] m_onehot();
        logic [NL-1:0] one;
        one = NL'(1);
        return one << (slot_cnt % NL);
    endfunction

    function automatic logic m_last();
        return (slot_cnt % NL) == NL - 1;
    endfunction

    // Called at a negedge; drives one cycle and returns at the next negedge.
    task automatic drive(input logic v, input logic s);
        valid    = v;
        soft_rst = s;
        @(posedge clk);
        if (s) slot_cnt = 0;
        else if (v) slot_cnt = slot_cnt + 1;
        @(negedge clk);
        valid    = 1'b0;
        soft_rst = 1'b0;
    endtask

    task automatic do_reset();
        valid    = 1'b0;
        soft_rst = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        slot_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (lane_id !== '0 || lane_onehot !== NL'(1) || am_insert !== 1'b1 ||
            last_lane !== 1'b0 || seq_err !== 1'b0) begin
            fails++;
            $display("FAIL reset: id=%0d oh=%h am=%b last=%b err=%b, required id=0 oh=00001 am=1 last=0 err=0",
                     lane_id, lane_onehot, am_insert, last_lane, seq_err);
        end
    endtask

    task automatic test_first_round();
        logic [NL-1:0] one;
        logic [NL-1:0] exp_oh;
        logic [LW-1:0] exp_id;
        one = NL'(1);
        do_reset();
        for (int i = 0; i < NL; i++) exp_q.push_back(LW'(i));
        for (int i = 0; i < NL; i++) begin
            exp_id = exp_q.pop_front();
            exp_oh = one << i;
            tests++;
            if (lane_id !== exp_id || lane_onehot !== exp_oh || am_insert !== 1'b1 ||
                last_lane !== (i == NL - 1)) begin
                fails++;
                $display("FAIL first_round slot %0d: id=%0d oh=%h am=%b last=%b, required id=%0d oh=%h am=1 last=%b",
                         i, lane_id, lane_onehot, am_insert, last_lane, exp_id, exp_oh, (i == NL - 1));
            end
            drive(1'b1, 1'b0);
        end
        tests++;
        if (lane_id !== '0 || am_insert !== 1'b0) begin
            fails++;
            $display("FAIL first_round wrap: id=%0d am=%b, required id=0 am=0", lane_id, am_insert);
        end
    endtask

    task automatic test_am_period();
        logic exp_am;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            exp_am = (k < 20) || (k >= 100 && k < 120);
            tests++;
            if (am_insert !== exp_am || lane_id !== LW'(k % NL)) begin
                fails++;
                $display("FAIL am_period slot %0d: am=%b id=%0d, required am=%b id=%0d",
                         k, am_insert, lane_id, exp_am, k % NL);
            end
            drive(1'b1, 1'b0);
        end
    endtask

    task automatic test_gaps();
        logic [LW-1:0] id_s;
        logic [NL-1:0] oh_s;
        logic          am_s;
        logic          last_s;
        int            guard;
        guard = 0;
        while (lane_id !== LW'(5) && guard < 40) begin
            drive(1'b1, 1'b0);
            guard++;
        end
        tests++;
        if (lane_id !== LW'(5)) begin
            fails++;
            $display("FAIL gaps reach_lane5: id=%0d, required 5", lane_id);
        end
        drive(1'b1, 1'b0);
        id_s = lane_id; oh_s = lane_onehot; am_s = am_insert; last_s = last_lane;
        tests++;
        if (id_s !== m_lane() || lane_id !== LW'(6)) begin
            fails++;
            $display("FAIL gaps advance: id=%0d, required 6", lane_id);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0);
            tests++;
            if (lane_id !== LW'(6) || lane_onehot !== oh_s || am_insert !== am_s || last_lane !== last_s) begin
                fails++;
                $display("FAIL gaps idle %0d: id=%0d oh=%h am=%b last=%b, required id=6 oh=%h am=%b last=%b",
                         i, lane_id, lane_onehot, am_insert, last_lane, oh_s, am_s, last_s);
            end
        end
        drive(1'b1, 1'b0);
        tests++;
        if (lane_id !== LW'(7) || lane_onehot !== m_onehot()) begin
            fails++;
            $display("FAIL gaps resume: id=%0d oh=%h, required id=7 oh=%h", lane_id, lane_onehot, m_onehot());
        end
    endtask

    task automatic test_soft_rst();
        do_reset();
        repeat (2 * NL + 13) drive(1'b1, 1'b0);
        tests++;
        if (lane_id !== LW'(13) || am_insert !== 1'b0) begin
            fails++;
            $display("FAIL soft_rst setup: id=%0d am=%b, required id=13 am=0", lane_id, am_insert);
        end
        drive(1'b1, 1'b1);
        tests++;
        if (lane_id !== '0 || lane_onehot !== NL'(1) || am_insert !== 1'b1) begin
            fails++;
            $display("FAIL soft_rst restart: id=%0d oh=%h am=%b, required id=0 oh=00001 am=1",
                     lane_id, lane_onehot, am_insert);
        end
        for (int i = 0; i < NL + 1; i++) begin
            tests++;
            if (am_insert !== (i < NL) || lane_id !== LW'(i % NL)) begin
                fails++;
                $display("FAIL soft_rst round slot %0d: am=%b id=%0d, required am=%b id=%0d",
                         i, am_insert, lane_id, (i < NL), i % NL);
            end
            drive(1'b1, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (9) drive(1'b1, 1'b0);
        tests++;
        if (lane_id !== LW'(9) || am_insert !== 1'b1) begin
            fails++;
            $display("FAIL async_reset setup: id=%0d am=%b, required id=9 am=1", lane_id, am_insert);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (lane_id !== '0 || lane_onehot !== NL'(1) || am_insert !== 1'b1 || seq_err !== 1'b0 ||
            last_lane !== 1'b0) begin
            fails++;
            $display("FAIL async_reset immediate: id=%0d oh=%h am=%b err=%b last=%b, required id=0 oh=00001 am=1 err=0 last=0",
                     lane_id, lane_onehot, am_insert, seq_err, last_lane);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        slot_cnt = 0;
    endtask

    task automatic test_random();
        logic v;
        logic s;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tests++;
            if (lane_id !== m_lane() || lane_onehot !== m_onehot() || am_insert !== m_am() ||
                last_lane !== m_last() || seq_err !== 1'b0) begin
                fails++;
                $display("FAIL random cycle %0d: id=%0d oh=%h am=%b last=%b err=%b, required id=%0d oh=%h am=%b last=%b err=0",
                         i, lane_id, lane_onehot, am_insert, last_lane, seq_err,
                         m_lane(), m_onehot(), m_am(), m_last());
            end
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 99) == 0);
            drive(v, s);
        end
    endtask

    task automatic test_seq_check();
`ifdef LANE_SEQ_CHECK_EN
        logic [NL-1:0] one;
        one = NL'(1);
        do_reset();
        force dut.onehot_q = NL'(20'h00003);
        @(posedge clk);
        @(negedge clk);
        release dut.onehot_q;
        tests++;
        if (seq_err !== 1'b1) begin
            fails++;
            $display("FAIL seq_check set: err=%b, required 1", seq_err);
        end
        drive(1'b0, 1'b0);
        tests++;
        if (seq_err !== 1'b1) begin
            fails++;
            $display("FAIL seq_check sticky: err=%b, required 1", seq_err);
        end
        drive(1'b1, 1'b0);
        tests++;
        if (lane_onehot !== (one << 1) || lane_id !== LW'(1) || seq_err !== 1'b1) begin
            fails++;
            $display("FAIL seq_check resync: oh=%h id=%0d err=%b, required oh=00002 id=1 err=1",
                     lane_onehot, lane_id, seq_err);
        end
        drive(1'b0, 1'b1);
        tests++;
        if (seq_err !== 1'b0) begin
            fails++;
            $display("FAIL seq_check clear: err=%b, required 0", seq_err);
        end
`else
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tests++;
            if (seq_err !== 1'b0) begin
                fails++;
                $display("FAIL seq_check tied: err=%b, required 0", seq_err);
            end
            drive(1'b1, 1'b0);
        end
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        valid    = 1'b0;
        soft_rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_round();
        test_am_period();
        test_gaps();
        test_soft_rst();
        test_async_reset();
        test_random();
        test_seq_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
